// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive monitor: FSM states, parity modes, divider floor.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  localparam int DIV_MIN     = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Frame queue: push/full write side, valid/ready read side, head shown straight from storage.
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  input  logic         rd_ready_i,
  output logic         rd_valid_o,
  output logic [W-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, rp_q;
  logic         empty, pop, wr;

  assign empty  = (wp_q == rp_q);
  assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop    = ~empty & rd_ready_i;
  // A pop frees the head slot at the same edge, so a full queue still takes the write.
  assign wr     = push_i & (~full_o | pop);

  assign rd_valid_o = ~empty;
  assign rd_data_o  = empty ? '0 : mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + (AW+1)'(1);
      if (pop) rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receive monitor: synchronise rx, sample bits mid-period, check parity/stop, queue frames.
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_W       = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_perr,
  output logic                 rd_ferr,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic                 busy
);

  localparam int FW = DATA_BITS + 2;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q, fall;
  logic [DIV_W-1:0]     div_sel;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d, cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 push_q, push_d, ovf_q, ovf_d;
  logic                 full, pop, drop, tick;
  logic [FW-1:0]        head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall    = rx_prev_q & ~rx_s2_q;
  assign div_sel = (cfg_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : cfg_div;
  assign tick    = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          div_d   = div_sel;
          cnt_d   = (div_sel >> 1) - DIV_W'(1);
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!tick) cnt_d = cnt_q - DIV_W'(1);
        else if (!rx_s2_q) begin
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = 4'd0;
          state_d = ST_DATA;
        end else state_d = ST_IDLE;
      end
      ST_DATA: begin
        if (!tick) cnt_d = cnt_q - DIV_W'(1);
        else begin
          shift_d = {rx_s2_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS-1)) begin
            bit_d   = 4'd0;
            state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (!tick) cnt_d = cnt_q - DIV_W'(1);
        else begin
          perr_d  = ((^shift_q) ^ rx_s2_q) ^ (PARITY_MODE == PARITY_ODD);
          cnt_d   = div_q - DIV_W'(1);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!tick) cnt_d = cnt_q - DIV_W'(1);
        else begin
          if (!rx_s2_q) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS-1)) begin
            push_d  = 1'b1;
            // A line still low here is a break; hold off until it idles again.
            state_d = rx_s2_q ? ST_IDLE : ST_BREAK;
          end else begin
            bit_d = bit_q + 4'd1;
            cnt_d = div_q - DIV_W'(1);
          end
        end
      end
      ST_BREAK: if (rx_s2_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      div_q   <= DIV_W'(DIV_MIN);
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      push_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      push_q  <= push_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pop   = rd_valid & rd_ready;
  assign drop  = push_q & full & ~pop;
  assign ovf_d = drop | (ovf_q & ~ovf_clr);

  uart_rx_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push_q),
    .wdata_i    ({ferr_q, perr_q, shift_q}),
    .full_o     (full),
    .rd_ready_i (rd_ready),
    .rd_valid_o (rd_valid),
    .rd_data_o  (head)
  );

  assign rd_data = head[DATA_BITS-1:0];
  assign rd_perr = head[DATA_BITS];
  assign rd_ferr = head[DATA_BITS+1];
  assign ovf     = ovf_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench: an 8N1 receiver (a) and a 7E2 receiver (b) driven by a bit-accurate serial task.
module tb_uart_rx_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_a, rx_b;
  logic [15:0] div_a, div_b;
  logic        rd_ready_a, rd_ready_b, ovf_clr_a, ovf_clr_b;
  logic        rd_valid_a, rd_perr_a, rd_ferr_a, ovf_a, busy_a;
  logic        rd_valid_b, rd_perr_b, rd_ferr_b, ovf_b, busy_b;
  logic [7:0]  rd_data_a;
  logic [6:0]  rd_data_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_capture u_a (
    .clk(clk), .resetn(resetn), .rx(rx_a), .cfg_div(div_a), .rd_ready(rd_ready_a),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_perr(rd_perr_a), .rd_ferr(rd_ferr_a),
    .ovf(ovf_a), .ovf_clr(ovf_clr_a), .busy(busy_a)
  );

  uart_rx_capture #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .resetn(resetn), .rx(rx_b), .cfg_div(div_b), .rd_ready(rd_ready_b),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_perr(rd_perr_b), .rd_ferr(rd_ferr_b),
    .ovf(ovf_b), .ovf_clr(ovf_clr_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // par < 0 means no parity bit; tail is the level left on the line afterwards.
  task automatic send_frame(input int sel, input int div, input int nbits, input logic [8:0] d,
                            input int par, input int nstop, input logic stop_v, input logic tail);
    set_line(sel, 1'b0);
    repeat (div) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, d[i]);
      repeat (div) @(negedge clk);
    end
    if (par >= 0) begin
      set_line(sel, par[0]);
      repeat (div) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(sel, stop_v);
      repeat (div) @(negedge clk);
    end
    set_line(sel, tail);
    repeat (div) @(negedge clk);
  endtask

  task automatic pop_a(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, " valid"}, rd_valid_a, 1);
    check({tag, " data"}, rd_data_a, d);
    check({tag, " perr"}, rd_perr_a, pe);
    check({tag, " ferr"}, rd_ferr_a, fe);
    rd_ready_a = 1'b1;
    @(negedge clk);
    rd_ready_a = 1'b0;
  endtask

  task automatic pop_b(input string tag, input logic [6:0] d, input logic pe, input logic fe);
    check({tag, " valid"}, rd_valid_b, 1);
    check({tag, " data"}, rd_data_b, d);
    check({tag, " perr"}, rd_perr_b, pe);
    check({tag, " ferr"}, rd_ferr_b, fe);
    rd_ready_b = 1'b1;
    @(negedge clk);
    rd_ready_b = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rx_a = 1'b1; rx_b = 1'b1; div_a = 16'd106; div_b = 16'd106;
    rd_ready_a = 1'b0; rd_ready_b = 1'b0; ovf_clr_a = 1'b0; ovf_clr_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst valid", rd_valid_a, 0);
    check("rst data", rd_data_a, 0);
    check("rst perr", rd_perr_a, 0);
    check("rst ferr", rd_ferr_a, 0);
    check("rst ovf", ovf_a, 0);
    check("rst busy", busy_a, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 bytes queue in order
    send_frame(0, 106, 8, 9'h055, -1, 1, 1'b1, 1'b1);
    send_frame(0, 106, 8, 9'h041, -1, 1, 1'b1, 1'b1);
    send_frame(0, 106, 8, 9'h000, -1, 1, 1'b1, 1'b1);
    send_frame(0, 106, 8, 9'h0FF, -1, 1, 1'b1, 1'b1);
    pop_a("t1 0x55", 8'h55, 0, 0);
    pop_a("t1 A", 8'h41, 0, 0);
    pop_a("t1 0x00", 8'h00, 0, 0);
    pop_a("t1 0xFF", 8'hFF, 0, 0);
    check("t1 empty", rd_valid_a, 0);

    // 7E2: 0x41 has two ones, so even parity bit is 0
    send_frame(1, 106, 7, 9'h041, 1, 2, 1'b1, 1'b1);
    pop_b("t2 bad par", 7'h41, 1, 0);
    send_frame(1, 106, 7, 9'h041, 0, 2, 1'b1, 1'b1);
    pop_b("t2 good par", 7'h41, 0, 0);

    // stop bit low, then line held low for 30 bit times
    send_frame(0, 106, 8, 9'h0A5, -1, 1, 1'b0, 1'b0);
    repeat (30 * 106) @(negedge clk);
    check("t3 busy in break", busy_a, 1);
    rx_a = 1'b1;
    repeat (106) @(negedge clk);
    check("t3 idle after break", busy_a, 0);
    pop_a("t3 ferr", 8'hA5, 0, 1);
    check("t3 no spurious", rd_valid_a, 0);
    send_frame(0, 106, 8, 9'h033, -1, 1, 1'b1, 1'b1);
    pop_a("t3 0x33", 8'h33, 0, 0);

    // overflow: eight kept, ninth dropped
    for (int i = 0; i < 9; i++) begin
      send_frame(0, 106, 8, 9'(8'h10 + i), -1, 1, 1'b1, 1'b1);
      if (i == 7) check("t4 ovf at full", ovf_a, 0);
    end
    check("t4 ovf set", ovf_a, 1);
    ovf_clr_a = 1'b1;
    @(negedge clk);
    ovf_clr_a = 1'b0;
    check("t4 ovf cleared", ovf_a, 0);
    // pop in exactly the push cycle (one cycle after busy falls)
    fork
      send_frame(0, 106, 8, 9'h020, -1, 1, 1'b1, 1'b1);
      begin
        int t;
        t = 0;
        while (!busy_a && t < 300) begin @(negedge clk); t++; end
        check("t4 busy rise", busy_a, 1);
        t = 0;
        while (busy_a && t < 2000) begin @(negedge clk); t++; end
        check("t4 busy fall", busy_a, 0);
        rd_ready_a = 1'b1;
        @(negedge clk);
        rd_ready_a = 1'b0;
      end
    join
    check("t4 no ovf on pop+push", ovf_a, 0);
    for (int i = 1; i < 8; i++) pop_a("t4 drain", 8'(8'h10 + i), 0, 0);
    pop_a("t4 last", 8'h20, 0, 0);
    check("t4 empty", rd_valid_a, 0);

    // 40-cycle glitch is shorter than half a bit
    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    check("t5 busy in glitch", busy_a, 1);
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (106) @(negedge clk);
    check("t5 glitch idle", busy_a, 0);
    check("t5 glitch nothing queued", rd_valid_a, 0);

    // 7E2 at cfg_div=16; 0x3C has four ones, 0x07 has three
    div_b = 16'd16;
    send_frame(1, 16, 7, 9'h03C, 0, 2, 1'b1, 1'b1);
    pop_b("t5 0x3C", 7'h3C, 0, 0);
    send_frame(1, 16, 7, 9'h007, 1, 2, 1'b1, 1'b1);
    pop_b("t5 0x07", 7'h07, 0, 0);
    fork
      send_frame(1, 16, 7, 9'h055, 0, 2, 1'b1, 1'b1);
      begin repeat (24) @(negedge clk); div_b = 16'd106; end
    join
    pop_b("t5 div change ignored", 7'h55, 0, 0);

    // reset mid-DATA with three entries queued
    send_frame(0, 106, 8, 9'h001, -1, 1, 1'b1, 1'b1);
    send_frame(0, 106, 8, 9'h002, -1, 1, 1'b1, 1'b1);
    send_frame(0, 106, 8, 9'h003, -1, 1, 1'b1, 1'b1);
    check("t6 queued", rd_valid_a, 1);
    rx_a = 1'b0;
    repeat (4 * 106) @(negedge clk);
    check("t6 busy mid frame", busy_a, 1);
    resetn = 1'b0;
    #1;
    check("t6 rst valid", rd_valid_a, 0);
    check("t6 rst busy", busy_a, 0);
    check("t6 rst data", rd_data_a, 0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (106) @(negedge clk);
    send_frame(0, 106, 8, 9'h096, -1, 1, 1'b1, 1'b1);
    pop_a("t6 after rst", 8'h96, 0, 0);
    check("t6 empty", rd_valid_a, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
